// File: rtl/zero_flag_pipe.sv
// Two-stage zero/negative flag pipeline with an NZCV flag register.
// Stage 1 OR-reduces CHUNK-bit groups; stage 2 NORs the group bits.
module zero_flag_pipe #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic             in_set_flags,
  output logic             out_valid,
  output logic             out_zero,
  output logic             out_negative,
  output logic [3:0]       flags
);

  localparam int G = WIDTH / CHUNK;

  logic [G-1:0] grp_d;
  logic [G-1:0] s1_grp;
  logic         s1_valid;
  logic         s1_msb;
  logic         s1_carry;
  logic         s1_ovf;
  logic         s1_set;
  logic         s1_zero;

  always_comb begin
    grp_d = '0;
    for (int g = 0; g < G; g++) begin
      grp_d[g] = |in_data[g*CHUNK +: CHUNK];
    end
  end

  assign s1_zero = ~|s1_grp;

  // Data regs load every cycle; only the valid bits see flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_grp   <= '0;
      s1_msb   <= 1'b0;
      s1_carry <= 1'b0;
      s1_ovf   <= 1'b0;
      s1_set   <= 1'b0;
    end else begin
      s1_valid <= in_valid & ~flush;
      s1_grp   <= grp_d;
      s1_msb   <= in_data[WIDTH-1];
      s1_carry <= in_carry;
      s1_ovf   <= in_overflow;
      s1_set   <= in_set_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_zero     <= 1'b0;
      out_negative <= 1'b0;
    end else begin
      out_valid    <= s1_valid & ~flush;
      out_zero     <= s1_zero;
      out_negative <= s1_msb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if (s1_valid && s1_set && !flush) begin
      flags <= {s1_msb, s1_zero, s1_carry, s1_ovf};
    end
  end

endmodule
